dsp_dot_seq: RTL and testbench

Sequencer that computes one signed dot product of up to N_MAX terms on a single shared 25x18 DSP MAC slice. The slice has A_REG/B_REG input stages, a multiplier register and a post-adder register, with p = m + pci. This block:

- reads operand pairs from two synchronous ROM/RAM ports;
- aligns the operands to the slice's input pipelines;
- drives pci to form a running accumulation;
- captures the final sum into a result register with valid/ready handoff.

It sits between the filter/correlator control logic and the DSP slice instance.

---
 rtl/dsp_dot_seq_if.sv | 35 +++
 rtl/dsp_dot_seq.sv | 122 ++++++++++++
 tb/tb_dsp_dot_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_dot_seq_if.sv
// Bundle between the dot-product sequencer, its operand memories, the DSP slice
// and the requester that starts a job and collects the result.
interface dsp_dot_seq_if #(
  parameter int N_MAX = 64,
  parameter int AW    = $clog2(N_MAX)
);
  logic               start;
  logic [AW:0]        len;
  logic               busy;
  logic               err;
  logic               x_rd;
  logic [AW-1:0]      x_addr;
  logic [AW-1:0]      c_addr;
  logic signed [24:0] x_data;
  logic signed [17:0] c_data;
  logic signed [24:0] dsp_a;
  logic signed [17:0] dsp_b;
  logic [47:0]        dsp_pci;
  logic [47:0]        dsp_p;
  logic signed [47:0] res;
  logic               res_valid;
  logic               res_ready;

  // Result handshake: res is offered while res_valid=1 and is held stable until
  // a cycle with res_valid & res_ready; res_valid never drops before that cycle.
  modport master (
    output start, len, x_data, c_data, dsp_p, res_ready,
    input  busy, err, x_rd, x_addr, c_addr, dsp_a, dsp_b, dsp_pci, res, res_valid
  );

  modport slave (
    input  start, len, x_data, c_data, dsp_p, res_ready,
    output busy, err, x_rd, x_addr, c_addr, dsp_a, dsp_b, dsp_pci, res, res_valid
  );
endinterface

// File: rtl/dsp_dot_seq.sv
// Signed dot-product sequencer driving one shared 25x18 DSP MAC slice, with
// operand alignment, first-term cascade gating and a held result register.
module dsp_dot_seq #(
  parameter int N_MAX = 64,
  parameter int A_REG = 2,
  parameter int B_REG = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  dsp_dot_seq_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int AW   = $clog2(N_MAX);
  localparam int PIPE = (A_REG > B_REG) ? A_REG : B_REG;
  localparam int DA   = PIPE - A_REG;
  localparam int DB   = PIPE - B_REG;
  localparam int TP   = PIPE + 2;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(N_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      addr;
  logic [AW:0]        len_q;
  logic               len_ok, accept, fetch_last, p_last, m_first, err_q;
  logic [TP:0]        tag_v, tag_l;
  logic [TP-1:0]      tag_f;
  logic signed [24:0] a_in;
  logic signed [17:0] b_in;
  logic signed [47:0] res_q;

  assign len_ok     = (bus.len != '0) && (bus.len <= LEN_MAX);
  assign accept     = (state == IDLE) && bus.start;
  assign fetch_last = ({1'b0, addr} == len_q - 1'b1);
  // Tag stage k is aligned with the operand presented k cycles earlier;
  // stage TP-1 is the multiplier register, stage TP the p register.
  assign p_last     = tag_v[TP] & tag_l[TP];
  assign m_first    = tag_v[TP-1] & tag_f[TP-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && len_ok) state_nxt = FETCH;
      FETCH:   if (fetch_last)       state_nxt = DRAIN;
      DRAIN:   if (p_last)           state_nxt = HOLD;
      HOLD:    if (bus.res_ready)    state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.x_rd      = (state == FETCH);
    bus.res_valid = (state == HOLD);
    bus.x_addr    = addr;
    bus.c_addr    = addr;
    bus.err       = err_q;
    bus.res       = res_q;
    bus.dsp_pci   = ((state == IDLE) || m_first) ? '0 : bus.dsp_p;
    dbg_state     = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      len_q <= '0;
      err_q <= 1'b0;
      tag_v <= '0;
      tag_f <= '0;
      tag_l <= '0;
      res_q <= '0;
    end else begin
      err_q <= accept && !len_ok;
      if (accept && len_ok) len_q <= bus.len;
      if ((state == FETCH) && !fetch_last) addr <= addr + 1'b1;
      else                                 addr <= '0;
      tag_v <= {tag_v[TP-1:0], (state == FETCH)};
      tag_f <= {tag_f[TP-2:0], (state == FETCH) && (addr == '0)};
      tag_l <= {tag_l[TP-1:0], (state == FETCH) && fetch_last};
      if ((state == DRAIN) && p_last) res_q <= bus.dsp_p;
    end
  end

  // Memory data is only meaningful the cycle after a read; zero it otherwise.
  assign a_in = tag_v[0] ? bus.x_data : '0;
  assign b_in = tag_v[0] ? bus.c_data : '0;

  if (DA == 0) begin : g_a_direct
    assign bus.dsp_a = a_in;
  end else begin : g_a_delay
    logic signed [24:0] a_dly [DA];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DA; i++) a_dly[i] <= '0;
      end else begin
        a_dly[0] <= a_in;
        for (int i = 1; i < DA; i++) a_dly[i] <= a_dly[i-1];
      end
    end
    assign bus.dsp_a = a_dly[DA-1];
  end

  if (DB == 0) begin : g_b_direct
    assign bus.dsp_b = b_in;
  end else begin : g_b_delay
    logic signed [17:0] b_dly [DB];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DB; i++) b_dly[i] <= '0;
      end else begin
        b_dly[0] <= b_in;
        for (int i = 1; i < DB; i++) b_dly[i] <= b_dly[i-1];
      end
    end
    assign bus.dsp_b = b_dly[DB-1];
  end
endmodule

// File: tb/tb_dsp_dot_seq.sv
// Bench for dsp_dot_seq: two instances (A=B=2 and A=3/B=1) with behavioural
// operand memories and DSP slices, scoreboard of expected dot products.
module tb_dsp_dot_seq;
  localparam int N_MAX = 64;
  localparam int AW    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_dot_seq_if #(.N_MAX(N_MAX)) b0();
  dsp_dot_seq_if #(.N_MAX(N_MAX)) b1();
  logic [1:0] dbg0, dbg1;

  dsp_dot_seq #(.N_MAX(N_MAX), .A_REG(2), .B_REG(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .dbg_state(dbg0));
  dsp_dot_seq #(.N_MAX(N_MAX), .A_REG(3), .B_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(dbg1));

  // ---------------- stimulus drive ----------------
  int          sel = 0;
  logic        start_v = 1'b0;
  logic [AW:0] len_v = '0;
  logic        ready_v = 1'b0;

  assign b0.start     = start_v && (sel == 0);
  assign b1.start     = start_v && (sel == 1);
  assign b0.len       = len_v;
  assign b1.len       = len_v;
  assign b0.res_ready = ready_v && (sel == 0);
  assign b1.res_ready = ready_v && (sel == 1);

  logic        o_busy, o_err, o_x_rd, o_res_valid;
  logic [AW-1:0] o_x_addr, o_c_addr;
  logic [24:0] o_dsp_a;
  logic [17:0] o_dsp_b;
  logic [47:0] o_pci, o_res;
  logic [1:0]  o_dbg;
  assign o_busy      = (sel == 0) ? b0.busy      : b1.busy;
  assign o_err       = (sel == 0) ? b0.err       : b1.err;
  assign o_x_rd      = (sel == 0) ? b0.x_rd      : b1.x_rd;
  assign o_res_valid = (sel == 0) ? b0.res_valid : b1.res_valid;
  assign o_x_addr    = (sel == 0) ? b0.x_addr    : b1.x_addr;
  assign o_c_addr    = (sel == 0) ? b0.c_addr    : b1.c_addr;
  assign o_dsp_a     = (sel == 0) ? b0.dsp_a     : b1.dsp_a;
  assign o_dsp_b     = (sel == 0) ? b0.dsp_b     : b1.dsp_b;
  assign o_pci       = (sel == 0) ? b0.dsp_pci   : b1.dsp_pci;
  assign o_res       = (sel == 0) ? b0.res       : b1.res;
  assign o_dbg       = (sel == 0) ? dbg0         : dbg1;

  // ---------------- operand memories (synchronous read) ----------------
  logic signed [24:0] x_mem [N_MAX];
  logic signed [17:0] c_mem [N_MAX];

  always @(posedge clk) begin
    if (b0.x_rd) begin
      b0.x_data <= x_mem[b0.x_addr];
      b0.c_data <= c_mem[b0.c_addr];
    end
    if (b1.x_rd) begin
      b1.x_data <= x_mem[b1.x_addr];
      b1.c_data <= c_mem[b1.c_addr];
    end
  end

  // ---------------- DSP slice models ----------------
  logic signed [24:0] s0_a [2];
  logic signed [17:0] s0_b [2];
  logic signed [47:0] s0_m = '0, s0_p = '0;
  always @(posedge clk) begin
    s0_a[0] <= b0.dsp_a;
    s0_a[1] <= s0_a[0];
    s0_b[0] <= b0.dsp_b;
    s0_b[1] <= s0_b[0];
    s0_m    <= s0_a[1] * s0_b[1];
    s0_p    <= s0_m + b0.dsp_pci;
  end
  assign b0.dsp_p = s0_p;

  logic signed [24:0] s1_a [3];
  logic signed [17:0] s1_b [1];
  logic signed [47:0] s1_m = '0, s1_p = '0;
  always @(posedge clk) begin
    s1_a[0] <= b1.dsp_a;
    s1_a[1] <= s1_a[0];
    s1_a[2] <= s1_a[1];
    s1_b[0] <= b1.dsp_b;
    s1_m    <= s1_a[2] * s1_b[0];
    s1_p    <= s1_m + b1.dsp_pci;
  end
  assign b1.dsp_p = s1_p;

  // ---------------- scoreboard ----------------
  logic [47:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [47:0] dot(input int ln);
    logic signed [47:0] acc, xa, cb;
    acc = '0;
    for (int i = 0; i < ln; i++) begin
      xa  = 48'(x_mem[i]);
      cb  = 48'(c_mem[i]);
      acc = acc + xa * cb;
    end
    return acc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},      64'(o_busy), 64'd0);
    check({pfx, "_err"},       64'(o_err), 64'd0);
    check({pfx, "_x_rd"},      64'(o_x_rd), 64'd0);
    check({pfx, "_x_addr"},    64'(o_x_addr), 64'd0);
    check({pfx, "_c_addr"},    64'(o_c_addr), 64'd0);
    check({pfx, "_dsp_a"},     64'(o_dsp_a), 64'd0);
    check({pfx, "_dsp_b"},     64'(o_dsp_b), 64'd0);
    check({pfx, "_dsp_pci"},   64'(o_pci), 64'd0);
    check({pfx, "_res"},       64'(o_res), 64'd0);
    check({pfx, "_res_valid"}, 64'(o_res_valid), 64'd0);
    check({pfx, "_state"},     64'(o_dbg), 64'd0);
  endtask

  // One job on instance s; expected result queued at start, checked on res_valid.
  task automatic run_job(input int s, input int ln, input logic [47:0] expv,
                         input int hold, input bit poke);
    int pipe, c;
    bit got;
    logic [47:0] exp_v;
    pipe = (s == 1) ? 3 : 2;
    exp_q.push_back(expv);
    tick();
    sel = s; start_v = 1'b1; len_v = (AW+1)'(ln); ready_v = (hold == 0);
    smp();
    check("busy_cycle0", 64'(o_busy), 64'd0);
    tick();
    start_v = 1'b0;
    c = 1; got = 1'b0;
    while (!got && c < 400) begin
      smp();
      if (c == 1) check("busy_cycle1", 64'(o_busy), 64'd1);
      if (c <= ln) begin
        check("x_rd_on", 64'(o_x_rd), 64'd1);
        check("x_addr",  64'(o_x_addr), 64'(c - 1));
        check("c_addr",  64'(o_c_addr), 64'(c - 1));
      end else if (c == ln + 1) begin
        check("x_rd_off", 64'(o_x_rd), 64'd0);
      end
      if (o_res_valid) got = 1'b1;
      else begin
        tick();
        c++;
      end
    end
    check("res_valid_seen", 64'(got), 64'd1);
    check("latency", 64'(c), 64'(ln + pipe + 4));
    exp_v = exp_q.pop_front();
    if (got) begin
      check("res", 64'(o_res), 64'(exp_v));
      for (int h = 1; h <= hold; h++) begin
        tick();
        ready_v = (h == hold);
        start_v = poke && ((h == 2) || (h == hold));
        smp();
        check("hold_valid", 64'(o_res_valid), 64'd1);
        check("hold_res",   64'(o_res), 64'(exp_v));
        check("hold_err",   64'(o_err), 64'd0);
        check("hold_busy",  64'(o_busy), 64'd1);
      end
      tick();
      start_v = 1'b0; ready_v = 1'b0;
      smp();
      check("post_valid", 64'(o_res_valid), 64'd0);
      check("post_busy",  64'(o_busy), 64'd0);
      check("post_err",   64'(o_err), 64'd0);
      check("post_res",   64'(o_res), 64'(exp_v));
    end
    start_v = 1'b0; ready_v = 1'b0;
  endtask

  task automatic reject_len(input int ln);
    tick();
    sel = 0; start_v = 1'b1; len_v = (AW+1)'(ln);
    tick();
    start_v = 1'b0;
    smp();
    check("illegal_err_pulse", 64'(o_err), 64'd1);
    check("illegal_busy",      64'(o_busy), 64'd0);
    check("illegal_x_rd",      64'(o_x_rd), 64'd0);
    check("illegal_res_valid", 64'(o_res_valid), 64'd0);
    tick();
    smp();
    check("illegal_err_clear", 64'(o_err), 64'd0);
    check("illegal_busy2",     64'(o_busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < N_MAX; i++) begin
      x_mem[i] = '0;
      c_mem[i] = '0;
    end
    smp();
    sel = 0; #1; check_idle_outputs("rst0");
    sel = 1; #1; check_idle_outputs("rst1");
    sel = 0;
    tick(); tick();
    rst_n = 1'b1;

    // Basic four-term job, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      x_mem[i] = 25'(i + 1);
      c_mem[i] = 18'(i + 5);
    end
    run_job(0, 4, 48'd70, 0, 1'b0);

    // Single-term extremes.
    x_mem[0] = -25'sd16777216;
    c_mem[0] = -18'sd131072;
    run_job(0, 1, 48'h200_0000_0000, 0, 1'b0);
    c_mem[0] = 18'sd131071;
    run_job(0, 1, -48'sd2199006478336, 0, 1'b0);

    // Backpressure with start pulses while holding the result.
    for (int i = 0; i < 6; i++) begin
      x_mem[i] = 25'(int'($urandom_range(0, 4000)) - 2000);
      c_mem[i] = 18'(int'($urandom_range(0, 600)) - 300);
    end
    run_job(0, 6, dot(6), 5, 1'b1);

    // Illegal lengths.
    reject_len(0);
    reject_len(N_MAX + 1);

    // Full-length job with full-range operands.
    for (int i = 0; i < N_MAX; i++) begin
      x_mem[i] = 25'($urandom);
      c_mem[i] = 18'($urandom);
    end
    run_job(0, N_MAX, dot(N_MAX), 2, 1'b0);

    // Reset in cycle 3 of a len=8 job, then a clean len=2 job.
    tick();
    sel = 0; start_v = 1'b1; len_v = 7'd8;
    tick(); start_v = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    tick();
    rst_n = 1'b1;
    x_mem[0] = 25'sd3;  c_mem[0] = 18'sd4;
    x_mem[1] = -25'sd2; c_mem[1] = 18'sd4;
    run_job(0, 2, 48'd4, 0, 1'b0);

    // Unequal input register depths: back-to-back ramp jobs then random data.
    for (int i = 0; i < N_MAX; i++) begin
      x_mem[i] = 25'(i);
      c_mem[i] = 18'sd1;
    end
    run_job(1, N_MAX, 48'd2016, 0, 1'b0);
    run_job(1, N_MAX, 48'd2016, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      x_mem[i] = 25'(int'($urandom_range(0, 100000)) - 50000);
      c_mem[i] = 18'(int'($urandom_range(0, 60000)) - 30000);
    end
    run_job(1, 7, dot(7), 1, 1'b0);
    run_job(1, 1, dot(1), 0, 1'b0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
